fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and the handshake with instruction memory.
- Presents the fetched instruction to decode; instrD[31:26] drives the main decoder opcode.
- Applies branch/jump redirects resolved in ID, honouring one architectural delay slot.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and IF/ID bundle for the fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [31:0] pcplus8;
        logic        valid;
    } if_id_t;

    function automatic logic [5:0] opcode(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and memory.
interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ready,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ready,
        output inst_rdata
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register: flush > stall > load > bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '{instr: NOP, pc: 32'd0, pcplus4: 32'd4,
                   pcplus8: 32'd8, valid: 1'b0};
        end else if (flush) begin
            q.instr <= NOP;
            q.valid <= 1'b0;
        end else if (stall) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end else begin
            // bubble keeps the pc fields so pcD stays put
            q.instr <= NOP;
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, pending redirect, hold buffer and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stallD,
    input  logic                 flushD,
    input  logic                 jumpD,
    input  logic [31:0]          jump_targetD,
    input  logic                 branch_takenD,
    input  logic [31:0]          branch_targetD,
    output logic [31:0]          instrD,
    output logic [31:0]          pcD,
    output logic [31:0]          pcplus4D,
    output logic [31:0]          pcplus8D,
    output logic                 validD,
    output logic                 fetch_busy
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pcF;
    logic [31:0] next_pc;
    logic [31:0] target;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        capture;
    logic        redirect_now;
    logic        load;
    if_id_t      d;
    if_id_t      q;

    assign capture      = (state == S_FETCH) && imem.inst_ready;
    assign redirect_now = q.valid && !stallD && (jumpD || branch_takenD);
    assign target       = jumpD ? jump_targetD : branch_targetD;

    assign next_pc = redirect_now ? target :
                     pend_valid   ? pend_target :
                                    pcF + 32'd4;

    assign imem.inst_req  = (state == S_FETCH) && !rst;
    assign imem.inst_addr = pcF;
    assign fetch_busy     = (state == S_FETCH) && !imem.inst_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pcF         <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= RESET_PC;
            hold_instr  <= NOP_INSTR;
            hold_pc     <= 32'd0;
        end else begin
            state <= state_nxt;
            // a redirect seen while waiting is replayed on completion
            if (capture) begin
                pcF        <= next_pc;
                pend_valid <= 1'b0;
            end else if (redirect_now) begin
                pend_target <= target;
                pend_valid  <= 1'b1;
            end
            if (capture && stallD && !flushD) begin
                hold_instr <= imem.inst_rdata;
                hold_pc    <= pcF;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = capture;
        d.instr   = imem.inst_rdata;
        d.pc      = pcF;
        unique case (state)
            S_FETCH: begin
                if (capture && stallD && !flushD) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                load    = 1'b1;
                d.instr = hold_instr;
                d.pc    = hold_pc;
                if (flushD || !stallD) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        d.pcplus4 = d.pc + 32'd4;
        d.pcplus8 = d.pc + 32'd8;
        d.valid   = 1'b1;
    end

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .stall (stallD),
        .flush (flushD),
        .d     (d),
        .q     (q)
    );

    assign instrD   = q.instr;
    assign pcD      = q.pc;
    assign pcplus4D = q.pcplus4;
    assign pcplus8D = q.pcplus8;
    assign validD   = q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard on delivered instructions.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        jumpD = 1'b0;
    logic [31:0] jump_targetD = '0;
    logic        branch_takenD = 1'b0;
    logic [31:0] branch_targetD = '0;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
    logic [31:0] pcplus8D;
    logic        validD;
    logic        fetch_busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_pc;

    fetch_stage_if imem();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .stallD         (stallD),
        .flushD         (flushD),
        .jumpD          (jumpD),
        .jump_targetD   (jump_targetD),
        .branch_takenD  (branch_takenD),
        .branch_targetD (branch_targetD),
        .instrD         (instrD),
        .pcD            (pcD),
        .pcplus4D       (pcplus4D),
        .pcplus8D       (pcplus8D),
        .validD         (validD),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem.inst_rdata = mem_word(imem.inst_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ID consumes the word whenever it holds a valid one and is not stalled
    always @(negedge clk) begin
        if (!rst && validD && !stallD) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc %h expected none", pcD);
            end else begin
                mon_pc = exp_q.pop_front();
                chk("sb_instr", instrD, mem_word(mon_pc));
                chk("sb_pc", pcD, mon_pc);
                chk("sb_pc4", pcplus4D, mon_pc + 32'd4);
                chk("sb_pc8", pcplus8D, mon_pc + 32'd8);
            end
        end
    end

    task automatic cyc(
        input logic        r_st,
        input logic        rdy,
        input logic        stl,
        input logic        fl,
        input logic        jmp,
        input logic [31:0] jt,
        input logic        br,
        input logic [31:0] bt,
        input logic [31:0] e_addr,
        input logic        e_req,
        input logic        e_busy,
        input logic        e_valid,
        input logic        push
    );
        rst             = r_st;
        imem.inst_ready = rdy;
        stallD          = stl;
        flushD          = fl;
        jumpD           = jmp;
        jump_targetD    = jt;
        branch_takenD   = br;
        branch_targetD  = bt;
        if (push) exp_q.push_back(e_addr);
        @(negedge clk);
        chk("inst_addr", imem.inst_addr, e_addr);
        chk("inst_req", 32'(imem.inst_req), 32'(e_req));
        chk("fetch_busy", 32'(fetch_busy), 32'(e_busy));
        chk("validD", 32'(validD), 32'(e_valid));
        if (!e_valid) chk("bubble_instr", instrD, NOP_INSTR_DEF);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem.inst_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem.inst_req), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_pcD", pcD, 32'd0);
        chk("rst_instrD", instrD, NOP_INSTR_DEF);
        chk("rst_validD", 32'(validD), 32'd0);
        chk("rst_addr", imem.inst_addr, RESET_PC_DEF);

        //  rst rdy stl fl jmp jt       br bt        addr     rq bsy vld push
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h00, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h04, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h08, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0C, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0C, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0C, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0C, 1, 0, 0, 1);
        // stall on capture of 0x10 parks it in the hold buffer
        cyc(0, 1, 1, 0, 0, 32'h0,  0, 32'h0,  32'h10, 1, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 32'h0,  0, 32'h0,  32'h14, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h14, 0, 0, 1, 0);
        // branch at 0x10: delay slot 0x14 then target 0x40
        cyc(0, 1, 0, 0, 0, 32'h0,  1, 32'h40, 32'h14, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h40, 1, 0, 1, 1);
        // jump during wait states wins over branch and is held pending
        cyc(0, 0, 0, 0, 1, 32'h80, 1, 32'h60, 32'h44, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h44, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h44, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h80, 1, 0, 1, 1);
        // flush in S_HOLD drops 0x84 and resumes at 0x88
        cyc(0, 1, 1, 0, 0, 32'h0,  0, 32'h0,  32'h84, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0, 32'h0,  0, 32'h0,  32'h88, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h88, 1, 0, 0, 1);
        // reset while waiting on 0x8C
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h8C, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h8C, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h8C, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h00, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h00, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h04, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h04, 1, 1, 0, 0);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
